// File: rtl/tpu_host_driver.sv
// Host-side driver for a 2x2 TPU: streams 8 operand bytes, waits for done,
// captures the 8 result bytes and hands the four 16-bit elements to a consumer.
module tpu_host_driver #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        cfg_transpose,
  input  logic        cfg_activation,
  input  logic [7:0]  op_data,
  input  logic        op_valid,
  output logic        op_ready,
  output logic [7:0]  tpu_ui_in,
  output logic [7:0]  tpu_uio_in,
  input  logic [7:0]  tpu_uo_out,
  input  logic [7:0]  tpu_uio_out,
  output logic [15:0] res_data,
  output logic [1:0]  res_idx,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        timeout_err
);

  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  state_t        state_r;
  logic [2:0]    byte_cnt_r;
  logic [WW-1:0] wait_cnt_r;
  logic [15:0]   res_buf_r [4];

  // Only the done flag of the TPU status byte is meaningful.
  logic unused_status_s;
  assign unused_status_s = ^tpu_uio_out[6:0];

  // Job sequencer: operand load, done wait, result capture and result drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      byte_cnt_r  <= 3'd0;
      wait_cnt_r  <= '0;
      op_ready    <= 1'b0;
      tpu_ui_in   <= 8'h00;
      tpu_uio_in  <= 8'h00;
      res_data    <= 16'h0000;
      res_idx     <= 2'd0;
      res_valid   <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        res_buf_r[i] <= 16'h0000;
      end
    end else begin
      // load_en is a single-cycle pulse unless a byte is accepted below
      tpu_uio_in[0] <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            // tpu_uio_in[2:1] doubles as the captured configuration
            tpu_uio_in  <= {5'b00000, cfg_activation, cfg_transpose, 1'b0};
            byte_cnt_r  <= 3'd0;
            timeout_err <= 1'b0;
            op_ready    <= 1'b1;
            busy        <= 1'b1;
            state_r     <= S_LOAD;
          end else begin
            tpu_uio_in  <= 8'h00;
          end
        end
        S_LOAD: begin
          if (op_valid) begin
            tpu_ui_in     <= op_data;
            tpu_uio_in[0] <= 1'b1;
            byte_cnt_r    <= byte_cnt_r + 3'd1;
            if (byte_cnt_r == 3'd7) begin
              op_ready   <= 1'b0;
              wait_cnt_r <= '0;
              state_r    <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (tpu_uio_out[7]) begin
            res_buf_r[0][7:0] <= tpu_uo_out;
            byte_cnt_r        <= 3'd1;
            state_r           <= S_CAPTURE;
          end else if (wait_cnt_r == WW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            tpu_uio_in  <= 8'h00;
            state_r     <= S_IDLE;
          end else begin
            wait_cnt_r  <= wait_cnt_r + WW'(1);
          end
        end
        S_CAPTURE: begin
          // byte k lands in element k/2, low half for even k
          if (byte_cnt_r[0]) begin
            res_buf_r[byte_cnt_r[2:1]][15:8] <= tpu_uo_out;
          end else begin
            res_buf_r[byte_cnt_r[2:1]][7:0]  <= tpu_uo_out;
          end
          byte_cnt_r <= byte_cnt_r + 3'd1;
          if (byte_cnt_r == 3'd7) begin
            res_valid  <= 1'b1;
            res_idx    <= 2'd0;
            res_data   <= res_buf_r[0];
            tpu_uio_in <= 8'h00;
            state_r    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (res_ready) begin
            if (res_idx == 2'd3) begin
              res_valid <= 1'b0;
              busy      <= 1'b0;
              state_r   <= S_IDLE;
            end else begin
              res_idx   <= res_idx + 2'd1;
              res_data  <= res_buf_r[res_idx + 2'd1];
            end
          end
        end
        default: begin
          op_ready   <= 1'b0;
          res_valid  <= 1'b0;
          busy       <= 1'b0;
          tpu_uio_in <= 8'h00;
          state_r    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tpu_host_driver.sv
// Directed bench for tpu_host_driver: behavioural 2x2 TPU, load-byte and result
// scoreboards, and per-step checks of reset, gaps, backpressure, timeout, cfg and abort.
`timescale 1ns/1ps
module tb_tpu_host_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        cfg_transpose;
  logic        cfg_activation;
  logic [7:0]  op_data;
  logic        op_valid;
  logic        op_ready;
  logic [7:0]  tpu_ui_in;
  logic [7:0]  tpu_uio_in;
  logic [7:0]  tpu_uo_out  = 8'h00;
  logic [7:0]  tpu_uio_out = 8'h15;
  logic [15:0] res_data;
  logic [1:0]  res_idx;
  logic        res_valid;
  logic        res_ready;
  logic        busy;
  logic        timeout_err;

  always #5 clk = ~clk;

  tpu_host_driver #(.TIMEOUT(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_transpose  (cfg_transpose),
    .cfg_activation (cfg_activation),
    .op_data        (op_data),
    .op_valid       (op_valid),
    .op_ready       (op_ready),
    .tpu_ui_in      (tpu_ui_in),
    .tpu_uio_in     (tpu_uio_in),
    .tpu_uo_out     (tpu_uo_out),
    .tpu_uio_out    (tpu_uio_out),
    .res_data       (res_data),
    .res_idx        (res_idx),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .busy           (busy),
    .timeout_err    (timeout_err)
  );

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          load_pulses = 0;
  int          last_pulse_cycle = 0;
  bit          res_seen = 1'b0;
  bit          tpu_done_en = 1'b1;
  logic [7:0]  load_q[$];
  logic [17:0] res_q[$];
  int          tpu_cnt = 0;
  logic [7:0]  tpu_bytes[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // C = W * X, bytes 0..3 are W row-major, bytes 4..7 are X row-major
  function automatic logic [15:0] mm(input logic [7:0] b[8], input int k);
    int r  = k / 2;
    int c  = k % 2;
    int w0 = int'(b[2*r]);
    int w1 = int'(b[2*r+1]);
    int x0 = int'(b[4+c]);
    int x1 = int'(b[6+c]);
    return 16'(w0 * x0 + w1 * x1);
  endfunction

  always @(posedge clk) cycle++;

  // TPU model: collects load_en bytes, raises done for one cycle 5 cycles later
  always begin
    @(posedge clk);
    if (!rst_n) begin
      tpu_cnt = 0;
    end else if (tpu_uio_in[0]) begin
      tpu_bytes[tpu_cnt] = tpu_ui_in;
      tpu_cnt++;
      if (tpu_cnt == 8) begin
        tpu_cnt = 0;
        if (tpu_done_en) begin
          repeat (4) @(posedge clk);
          for (int k = 0; k < 8; k++) begin
            logic [15:0] v;
            v = mm(tpu_bytes, k / 2);
            #1;
            tpu_uio_out = (k == 0) ? 8'h95 : 8'h15;
            tpu_uo_out  = (k % 2 == 0) ? v[7:0] : v[15:8];
            @(posedge clk);
          end
          #1;
          tpu_uio_out = 8'h15;
          tpu_uo_out  = 8'h00;
        end
      end
    end
  end

  // Scoreboards: operand bytes against load_en pulses, results against handshakes
  always @(negedge clk) begin
    if (tpu_uio_in[0] === 1'b1) begin
      load_pulses++;
      last_pulse_cycle = cycle;
      check("load_q_avail", 32'(load_q.size() > 0), 32'd1);
      if (load_q.size() > 0) check("tpu_ui_in", tpu_ui_in, load_q.pop_front());
    end
    if (op_ready === 1'b1 && op_valid === 1'b1) load_q.push_back(op_data);
    if (res_valid === 1'b1) begin
      res_seen = 1'b1;
      check("res_q_avail", 32'(res_q.size() > 0), 32'd1);
      if (res_q.size() > 0) begin
        check("res_idx", res_idx, res_q[0][17:16]);
        check("res_data", res_data, res_q[0][15:0]);
        if (res_ready) void'(res_q.pop_front());
      end
    end
  end

  task automatic expect_job(input logic [15:0] e[4]);
    for (int k = 0; k < 4; k++) res_q.push_back({2'(k), e[k]});
  endtask

  task automatic start_job(input bit tr, input bit act);
    start = 1'b1;
    cfg_transpose = tr;
    cfg_activation = act;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_transpose = 1'b0;
    cfg_activation = 1'b0;
    check("busy_after_start", busy, 32'd1);
    check("op_ready_in_load", op_ready, 32'd1);
    check("timeout_err_cleared", timeout_err, 32'd0);
    check("uio_first_load", tpu_uio_in, {24'd0, 5'd0, act, tr, 1'b0});
  endtask

  task automatic load_bytes(input logic [7:0] b[8], input int n, input bit gap, input logic [1:0] cfg);
    for (int i = 0; i < n; i++) begin
      check("op_ready_before_byte", op_ready, 32'd1);
      op_data = b[i];
      op_valid = 1'b1;
      @(posedge clk); #1;
      op_valid = 1'b0;
      check("uio_load_pulse", tpu_uio_in, {24'd0, 5'd0, cfg, 1'b1});
      if (gap && i < n - 1) begin
        @(posedge clk); #1;
        check("uio_gap_no_pulse", tpu_uio_in, {24'd0, 5'd0, cfg, 1'b0});
      end
    end
    if (n == 8) begin
      check("op_ready_drop", op_ready, 32'd0);
      @(posedge clk); #1;
      check("uio_wait", tpu_uio_in, {24'd0, 5'd0, cfg, 1'b0});
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || res_q.size() != 0) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("job_done_in_budget", 32'(n < budget), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed=still running expected=finished");
    $fatal(1);
  end

  initial begin
    logic [7:0]  ba[8];
    logic [7:0]  bb[8];
    logic [15:0] ea[4];
    logic [15:0] eb[4];
    int          n;
    ba = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    bb = '{8'd200, 8'd100, 8'd128, 8'd255, 8'd150, 8'd3, 8'd90, 8'd60};
    ea = '{16'd19, 16'd22, 16'd43, 16'd50};
    eb = '{16'd39000, 16'd6600, 16'd42150, 16'd15684};

    rst_n = 1'b0; start = 1'b0; cfg_transpose = 1'b0; cfg_activation = 1'b0;
    op_data = 8'h00; op_valid = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("rst_op_ready", op_ready, 32'd0);
    check("rst_res_valid", res_valid, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_timeout_err", timeout_err, 32'd0);
    check("rst_tpu_ui_in", tpu_ui_in, 32'd0);
    check("rst_tpu_uio_in", tpu_uio_in, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_idx", res_idx, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic back-to-back job
    load_pulses = 0;
    start_job(1'b0, 1'b0);
    expect_job(ea);
    load_bytes(ba, 8, 1'b0, 2'b00);
    wait_idle(100);
    check("basic_pulses", load_pulses, 32'd8);

    // gapped load, with a stray start during WAIT that must be ignored
    load_pulses = 0;
    start_job(1'b0, 1'b0);
    expect_job(ea);
    load_bytes(ba, 8, 1'b1, 2'b00);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(100);
    check("gapped_pulses", load_pulses, 32'd8);
    repeat (3) @(posedge clk); #1;
    check("stray_start_ignored", busy, 32'd0);

    // backpressure in DRAIN
    res_ready = 1'b0;
    start_job(1'b0, 1'b0);
    expect_job(ea);
    load_bytes(ba, 8, 1'b0, 2'b00);
    n = 0;
    while (res_valid !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check("res_valid_in_budget", 32'(n < 60), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("bp_res_data", res_data, 32'h0013);
      check("bp_res_idx", res_idx, 32'd0);
      @(posedge clk); #1;
    end
    res_ready = 1'b1;
    wait_idle(100);

    // wide unsigned results pass through unmodified
    start_job(1'b0, 1'b0);
    expect_job(eb);
    load_bytes(bb, 8, 1'b0, 2'b00);
    wait_idle(100);

    // timeout: done never rises
    tpu_done_en = 1'b0;
    res_seen = 1'b0;
    start_job(1'b0, 1'b0);
    load_bytes(ba, 8, 1'b0, 2'b00);
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_in_budget", 32'(n < 40), 32'd1);
    check("timeout_wait_cycles", cycle - last_pulse_cycle, 32'd16);
    check("timeout_busy", busy, 32'd0);
    @(posedge clk); #1;
    check("timeout_sticky", timeout_err, 32'd1);
    check("timeout_no_results", res_seen, 32'd0);
    tpu_done_en = 1'b1;
    for (int k = 0; k < 4; k++) eb[k] = mm(bb, k);
    start_job(1'b0, 1'b0);
    expect_job(eb);
    load_bytes(bb, 8, 1'b0, 2'b00);
    wait_idle(100);

    // configuration bits captured at start
    start_job(1'b1, 1'b1);
    expect_job(ea);
    load_bytes(ba, 8, 1'b0, 2'b11);
    wait_idle(100);

    // reset mid-LOAD after 3 bytes, then a full job
    load_pulses = 0;
    res_seen = 1'b0;
    start_job(1'b0, 1'b1);
    load_bytes(ba, 3, 1'b0, 2'b10);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_op_ready", op_ready, 32'd0);
    check("abort_busy", busy, 32'd0);
    check("abort_tpu_ui_in", tpu_ui_in, 32'd0);
    check("abort_tpu_uio_in", tpu_uio_in, 32'd0);
    check("abort_res_valid", res_valid, 32'd0);
    check("abort_res_data", res_data, 32'd0);
    repeat (10) @(posedge clk); #1;
    check("abort_pulses", load_pulses, 32'd3);
    check("abort_no_results", res_seen, 32'd0);
    load_pulses = 0;
    start_job(1'b0, 1'b0);
    expect_job(ea);
    load_bytes(ba, 8, 1'b0, 2'b00);
    wait_idle(100);
    check("after_abort_pulses", load_pulses, 32'd8);
    check("load_q_drained", load_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_host_driver.md
TPU_HOST_DRIVER -- requirements
Module: tpu_host_driver

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles waited for TPU done before aborting.
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port start  input  1  begin a job; sampled only in IDLE.
REQ-005 SHALL have port cfg_transpose  input  1  transpose mode; captured at start.
REQ-006 SHALL have port cfg_activation  input  1  activation (ReLU) enable; captured at start.
REQ-007 SHALL have port op_data  input  8  operand byte: 4 weights, then 4 inputs.
REQ-008 SHALL have port op_valid  input  1  op_data valid.
REQ-009 SHALL have port op_ready  output  1  driver accepts op_data this cycle.
REQ-010 SHALL have port tpu_ui_in  output  8  data byte to TPU.
REQ-011 SHALL have port tpu_uio_in  output  8  TPU control: bit0 load_en, bit1 transpose, bit2 activation, bits7:3 zero.
REQ-012 SHALL have port tpu_uo_out  input  8  result byte from TPU.
REQ-013 SHALL have port tpu_uio_out  input  8  TPU status; bit7 = done, others ignored.
REQ-014 SHALL have port res_data  output  16  result element.
REQ-015 SHALL have port res_idx  output  2  element index: 0=c00, 1=c01, 2=c10, 3=c11.
REQ-016 SHALL have port res_valid  output  1  res_data/res_idx valid.
REQ-017 SHALL have port res_ready  input  1  consumer accepts result.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.
REQ-019 SHALL have port timeout_err  output  1  sticky; set on done timeout, cleared by next accepted start.

Function
REQ-020 SHALL implement states IDLE, LOAD, WAIT, CAPTURE, DRAIN.
REQ-021 IDLE: start=1 SHALL register cfg bits, clear byte counter, clear timeout_err, go to LOAD next cycle.
REQ-022 LOAD: op_ready SHALL be 1; each cycle with op_valid=1 SHALL accept one byte and increment a 3-bit byte counter.
REQ-023 Accepted byte SHALL appear on tpu_ui_in with load_en=1 on the following cycle (registered, 1-cycle latency); cycles without an accept SHALL drive load_en=0.
REQ-024 tpu_uio_in bits1:2 SHALL carry registered cfg bits from LOAD through CAPTURE; SHALL be 0 in IDLE.
REQ-025 After 8th accept, SHALL go to WAIT; op_ready SHALL drop same cycle the counter wraps to 0; load_en for byte 8 still issues next cycle.
REQ-026 WAIT: load_en=0; SHALL count cycles from 0; on tpu_uio_out[7]=1 SHALL go to CAPTURE, capturing tpu_uo_out of that same cycle as byte 0.
REQ-027 WAIT: if counter reaches TIMEOUT with done still 0, SHALL set timeout_err, go to IDLE, emit no results.
REQ-028 CAPTURE: SHALL sample tpu_uo_out on 8 consecutive cycles (byte 0 on done cycle), order c00 lo, c00 hi, c01 lo, c01 hi, c10 lo, c10 hi, c11 lo, c11 hi, into a 4x16 buffer; done deasserting mid-capture SHALL be ignored.
REQ-029 After byte 7, SHALL go to DRAIN with element index 0.
REQ-030 DRAIN: res_valid=1, res_data=buffer[idx], res_idx=idx; on res_valid&res_ready idx SHALL increment; after idx 3 accepted, SHALL go to IDLE.
REQ-031 res_data/res_idx SHALL remain stable while res_valid=1 and res_ready=0.
REQ-032 start outside IDLE SHALL be ignored; start in the same cycle as the DRAIN-to-IDLE transition SHALL be ignored (taken only when state is IDLE).
REQ-033 Results SHALL be passed unmodified; no sign extension or saturation.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE, op_ready=0, res_valid=0, busy=0, timeout_err=0, tpu_ui_in=0, tpu_uio_in=0, res_data=0, res_idx=0, counters and buffer cleared.
REQ-035 Reset mid-job (any state) SHALL abort with no further load_en pulses or results; next start SHALL begin a full job.

Verification
REQ-036 Basic: start, bytes 1,2,3,4,5,6,7,8 back-to-back; TPU model raises done 5 cycles later and streams 0x13,0x00,0x16,0x00,0x2B,0x00,0x32,0x00 -> 8 consecutive load_en pulses with matching tpu_ui_in; results 19,22,43,50 with idx 0..3.
REQ-037 Gapped load: op_valid low every other cycle -> load_en pulses only on accept-following cycles; exactly 8 pulses; same results as REQ-036.
REQ-038 Backpressure: res_ready held 0 for 4 cycles in DRAIN -> res_data=0x0013, idx=0 held stable; then 4 results in order.
REQ-039 Timeout: TIMEOUT=16, done never asserted -> timeout_err=1 after 16 WAIT cycles, busy=0, res_valid never 1; next start clears timeout_err.
REQ-040 Config: cfg_transpose=1, cfg_activation=1 at start, changed to 0 afterwards -> tpu_uio_in=0x07 on load cycles, 0x06 in WAIT.
REQ-041 Reset mid-LOAD after 3 bytes -> all outputs zero next cycle; new job loads all 8 bytes and returns correct results.
